i2s_rx_capture: RTL and testbench

I2S receive front end for the audio codec ADC path. It samples the codec's SCLK, LRCLK and Din pins in the CLK domain and deserializes left and right words. Complete stereo frames are buffered in a small FIFO and presented on a valid/ready stream to the downstream mixing and playback logic, alongside the keycode synthesizer. It also exposes overflow and framing-error status for software.

---
 rtl/i2s_rx_capture.sv | 187 ++++++++++++++++++
 tb/tb_i2s_rx_capture.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_capture.sv
// I2S receive front end: synchronizes SCLK/LRCLK/Din, deserializes left/right words
// and queues complete stereo frames in a show-ahead FIFO with overflow/framing status.
module i2s_rx_capture #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          enable,
  input  logic                          SCLK,
  input  logic                          LRCLK,
  input  logic                          Din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_left,
  output logic [DATA_WIDTH-1:0]         out_right,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          short_word,
  input  logic                          clear_status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BITS_FULL  = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] BITS_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

  // Pin order in the synchronizer vectors: {SCLK, LRCLK, Din}
  logic [2:0] sync1_reg, sync2_reg;
  logic       sclk_hist_reg, rise_reg, lrclk_s_reg, din_s_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      sclk_hist_reg <= 1'b0;
      rise_reg      <= 1'b0;
      lrclk_s_reg   <= 1'b0;
      din_s_reg     <= 1'b0;
    end else begin
      sync1_reg     <= {SCLK, LRCLK, Din};
      sync2_reg     <= sync1_reg;
      sclk_hist_reg <= sync2_reg[2];
      rise_reg      <= sync2_reg[2] & ~sclk_hist_reg;
      lrclk_s_reg   <= sync2_reg[1];
      din_s_reg     <= sync2_reg[0];
    end
  end

  logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
  logic [DATA_WIDTH-1:0] left_hold_reg, left_hold_next;
  logic                  left_ok_reg, left_ok_next;
  logic                  chan_reg, chan_next;
  logic                  chan_valid_reg, chan_valid_next;
  logic                  lr_prev_reg, lr_prev_next;
  logic                  seen_reg, seen_next;
  logic                  push_req_reg, push_req_next;
  logic                  short_evt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt_reg    <= BITS_FULL;
      shreg_reg      <= '0;
      left_hold_reg  <= '0;
      left_ok_reg    <= 1'b0;
      chan_reg       <= 1'b0;
      chan_valid_reg <= 1'b0;
      lr_prev_reg    <= 1'b0;
      seen_reg       <= 1'b0;
      push_req_reg   <= 1'b0;
    end else begin
      bit_cnt_reg    <= bit_cnt_next;
      shreg_reg      <= shreg_next;
      left_hold_reg  <= left_hold_next;
      left_ok_reg    <= left_ok_next;
      chan_reg       <= chan_next;
      chan_valid_reg <= chan_valid_next;
      lr_prev_reg    <= lr_prev_next;
      seen_reg       <= seen_next;
      push_req_reg   <= push_req_next;
    end
  end

  // A word only counts as framed (chan_valid) when its delay slot was preceded by
  // another enabled rise, so the first LRCLK edge seen after reset/enable is ignored.
  always_comb begin
    bit_cnt_next    = bit_cnt_reg;
    shreg_next      = shreg_reg;
    left_hold_next  = left_hold_reg;
    left_ok_next    = left_ok_reg;
    chan_next       = chan_reg;
    chan_valid_next = chan_valid_reg;
    lr_prev_next    = lr_prev_reg;
    seen_next       = seen_reg;
    push_req_next   = 1'b0;
    short_evt       = 1'b0;
    if (!enable) begin
      bit_cnt_next    = BITS_FULL;
      left_ok_next    = 1'b0;
      chan_valid_next = 1'b0;
      seen_next       = 1'b0;
    end else if (rise_reg) begin
      seen_next = 1'b1;
      if (lrclk_s_reg != lr_prev_reg) begin
        lr_prev_next    = lrclk_s_reg;
        bit_cnt_next    = '0;
        chan_next       = lrclk_s_reg;
        chan_valid_next = seen_reg;
        short_evt       = chan_valid_reg && (bit_cnt_reg < BITS_FULL);
        if (!lrclk_s_reg) left_ok_next = 1'b0;
      end else if (bit_cnt_reg < BITS_FULL) begin
        shreg_next   = {shreg_reg[DATA_WIDTH-2:0], din_s_reg};
        bit_cnt_next = bit_cnt_reg + BW'(1);
        if (bit_cnt_reg == BITS_LAST) begin
          if (!chan_reg) begin
            left_hold_next = shreg_next;
            left_ok_next   = 1'b1;
          end else if (left_ok_reg) begin
            push_req_next = 1'b1;
            left_ok_next  = 1'b0;
          end
        end
      end
    end
  end

  logic [2*DATA_WIDTH-1:0] mem_reg [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]             level_reg;
  logic                    overflow_reg, short_word_reg;
  logic [CNT_WIDTH-1:0]    drop_count_reg;
  logic                    pop, full, wr_en, drop;

  assign pop   = (level_reg != '0) && out_ready;
  assign full  = (level_reg == LEVEL_FULL);
  assign wr_en = push_req_reg && (!full || pop);
  assign drop  = push_req_reg && full && !pop;

  // Right word stays in shreg_reg until the next rise, so the frame is written from it directly
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) begin
        mem_reg[wr_ptr_reg] <= {left_hold_reg, shreg_reg};
        wr_ptr_reg          <= wr_ptr_reg + AW'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (wr_en && !pop)      level_reg <= level_reg + (AW + 1)'(1);
      else if (!wr_en && pop) level_reg <= level_reg - (AW + 1)'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
      short_word_reg <= 1'b0;
    end else if (clear_status) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
      short_word_reg <= 1'b0;
    end else begin
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != {CNT_WIDTH{1'b1}}) drop_count_reg <= drop_count_reg + CNT_WIDTH'(1);
      end
      if (short_evt) short_word_reg <= 1'b1;
    end
  end

  assign out_valid  = (level_reg != '0);
  assign out_left   = mem_reg[rd_ptr_reg][2*DATA_WIDTH-1:DATA_WIDTH];
  assign out_right  = mem_reg[rd_ptr_reg][DATA_WIDTH-1:0];
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;
  assign short_word = short_word_reg;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Directed bench for i2s_rx_capture: bit-banged I2S source, frame scoreboard
// checked on every FIFO pop, plus latency, overflow, short-word and reset checks.
module tb_i2s_rx_capture;

  localparam int DW    = 24;
  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic          CLK, RESET, enable, SCLK, LRCLK, Din, out_ready, clear_status;
  logic          out_valid, overflow, short_word;
  logic [DW-1:0] out_left, out_right;
  logic [3:0]    fifo_level;
  logic [CW-1:0] drop_count;

  int tests = 0;
  int fails = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] mon_exp;

  i2s_rx_capture #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .SCLK(SCLK), .LRCLK(LRCLK), .Din(Din),
    .out_valid(out_valid), .out_ready(out_ready), .out_left(out_left), .out_right(out_right),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count),
    .short_word(short_word), .clear_status(clear_status)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted head frame must match the oldest expected frame
  always @(negedge CLK) begin
    if (RESET === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_frame: observed %0h expected none", {out_left, out_right});
        end
      end else begin
        mon_exp = exp_q.pop_front();
        check("frame", {16'h0, out_left, out_right}, {16'h0, mon_exp});
        $display("[TB] frame L=%06h R=%06h", out_left, out_right);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  // One SCLK period = 8 CLK; data changes while SCLK is low
  task automatic bit_out(input logic lr, input logic d);
    SCLK = 1'b0; LRCLK = lr; Din = d;
    repeat (4) cyc();
    SCLK = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic send_word(input logic lr, input logic [DW-1:0] w, input int nbits);
    bit_out(lr, 1'b1);
    for (int i = 0; i < nbits; i++) bit_out(lr, w[DW-1-i]);
  endtask

  // Sends a frame but returns right after raising SCLK for the final right bit
  task automatic open_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [DW-1:0] rv;
    rv = r;
    send_word(1'b0, l, DW);
    send_word(1'b1, r, DW - 1);
    SCLK = 1'b0; LRCLK = 1'b1; Din = rv[0];
    repeat (4) cyc();
    SCLK = 1'b1;
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit expect_out);
    if (expect_out) exp_q.push_back({l, r});
    open_frame(l, r);
    repeat (6) cyc();
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && fifo_level != 0; i++) cyc();
    check({tag, "_level"}, 64'(fifo_level), 64'd0);
    check({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    RESET = 1'b1; enable = 1'b0; SCLK = 1'b0; LRCLK = 1'b0; Din = 1'b0;
    out_ready = 1'b0; clear_status = 1'b0;
    repeat (3) cyc();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_left", 64'(out_left), 64'd0);
    check("rst_right", 64'(out_right), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_short", 64'(short_word), 64'd0);
    RESET = 1'b0; enable = 1'b1;
    cyc();

    // 1: pattern readback with exact out_valid latency
    out_ready = 1'b1;
    bit_out(1'b1, 1'b0);
    bit_out(1'b1, 1'b0);
    exp_q.push_back({24'hA5A5A5, 24'h3C3C3C});
    open_frame(24'hA5A5A5, 24'h3C3C3C);
    repeat (4) cyc();
    check("lat_early", 64'(out_valid), 64'd0);
    cyc();
    check("lat_on", 64'(out_valid), 64'd1);
    cyc();
    check("lat_pulse", 64'(out_valid), 64'd0);
    check("t1_queue", 64'(exp_q.size()), 64'd0);

    // 2: startup mid-right word
    RESET = 1'b1; cyc(); RESET = 1'b0; cyc();
    for (int i = 0; i < 10; i++) bit_out(1'b1, 1'(i & 1));
    send_frame(24'h000001, 24'h800000, 1'b1);
    repeat (4) cyc();
    check("t2_short", 64'(short_word), 64'd0);
    check("t2_queue", 64'(exp_q.size()), 64'd0);

    // 3: overflow, in-order drain, clear
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) send_frame(DW'(i), DW'(i) ^ 24'hF00000, i <= DEPTH);
    repeat (2) cyc();
    check("t3_level", 64'(fifo_level), 64'd8);
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_drop", 64'(drop_count), 64'd2);
    check("t3_head", 64'(out_left), 64'd1);
    drain("t3_drain");
    clear_status = 1'b1; cyc(); clear_status = 1'b0;
    check("t3_clr_overflow", 64'(overflow), 64'd0);
    check("t3_clr_drop", 64'(drop_count), 64'd0);

    // 4: full FIFO with pop on the same edge as the ninth write
    out_ready = 1'b0;
    for (int i = 11; i <= 18; i++) send_frame(DW'(i), DW'(i) + 24'h500000, 1'b1);
    check("t4_full", 64'(fifo_level), 64'd8);
    exp_q.push_back({24'd19, 24'd19 + 24'h500000});
    open_frame(24'd19, 24'd19 + 24'h500000);
    repeat (4) cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    cyc();
    check("t4_level", 64'(fifo_level), 64'd8);
    check("t4_overflow", 64'(overflow), 64'd0);
    check("t4_drop", 64'(drop_count), 64'd0);
    drain("t4_drain");

    // 5: short left word, then recovery
    check("t5_short_pre", 64'(short_word), 64'd0);
    send_word(1'b0, 24'h123456, 16);
    send_word(1'b1, 24'h654321, DW);
    repeat (4) cyc();
    check("t5_short", 64'(short_word), 64'd1);
    check("t5_no_push", 64'(fifo_level), 64'd0);
    send_frame(24'hABCDEF, 24'h012345, 1'b1);
    repeat (4) cyc();
    check("t5_queue", 64'(exp_q.size()), 64'd0);
    clear_status = 1'b1; cyc(); clear_status = 1'b0;
    check("t5_clr_short", 64'(short_word), 64'd0);

    // 6: asynchronous reset mid-left word with frames queued
    out_ready = 1'b0;
    send_frame(24'hC00001, 24'hD00001, 1'b1);
    send_frame(24'hC00002, 24'hD00002, 1'b1);
    send_frame(24'hC00003, 24'hD00003, 1'b1);
    check("t6_level", 64'(fifo_level), 64'd3);
    check("t6_head", 64'(out_left), 64'hC00001);
    send_word(1'b0, 24'hFFFFFF, 10);
    RESET = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_left", 64'(out_left), 64'd0);
    check("t6_rst_right", 64'(out_right), 64'd0);
    check("t6_rst_level", 64'(fifo_level), 64'd0);
    exp_q.delete();
    cyc(); RESET = 1'b0; cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) bit_out(1'b0, 1'b1);
    send_word(1'b1, 24'h777777, DW);
    send_frame(24'h111111, 24'h222222, 1'b1);
    repeat (4) cyc();
    check("t6_resume_queue", 64'(exp_q.size()), 64'd0);

    enable = 1'b0;
    send_frame(24'h555555, 24'h666666, 1'b0);
    send_frame(24'h888888, 24'h999999, 1'b0);
    check("t6_dis_level", 64'(fifo_level), 64'd0);
    enable = 1'b1;
    send_frame(24'h333333, 24'h444444, 1'b1);
    repeat (4) cyc();
    check("t6_en_queue", 64'(exp_q.size()), 64'd0);
    check("t6_en_level", 64'(fifo_level), 64'd0);
    check("t6_short", 64'(short_word), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
